// File: rtl/flatten_frame_sequencer_pkg.sv
// Shared geometry, ordering and state definitions for the flatten frame sequencer.
package flatten_frame_sequencer_pkg;
  localparam int H  = 14;
  localparam int W  = 14;
  localparam int C  = 16;
  localparam int HW = H * W;
  localparam int N  = HW * C;
  localparam int DW = 8;
  localparam int AW = 12;

  localparam int ORDER_CHW = 0;
  localparam int ORDER_HWC = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } state_e;
endpackage

// File: rtl/fm_addr_gen.sv
// Incremental feature-map address walker; CHW is a plain counter, HWC walks
// channels innermost by striding one plane (H*W) per step.
module fm_addr_gen
  import flatten_frame_sequencer_pkg::*;
#(
  parameter int ORDER = ORDER_CHW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          step_i,
  input  logic          clear_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);

  logic [AW-1:0] addr_q, addr_d;

  generate
    if (ORDER == ORDER_HWC) begin : g_hwc
      localparam int CW = $clog2(C);
      localparam logic [CW-1:0] C_LAST = CW'(C - 1);
      localparam logic [AW-1:0] P_LAST = AW'(HW - 1);
      logic [AW-1:0] p_q, p_d;
      logic [CW-1:0] c_q, c_d;

      always_comb begin
        p_d    = p_q;
        c_d    = c_q;
        addr_d = addr_q;
        if (clear_i) begin
          p_d    = '0;
          c_d    = '0;
          addr_d = '0;
        end else if (step_i) begin
          if (c_q == C_LAST) begin
            // Channel wrap: back to plane 0 at the next spatial position.
            c_d    = '0;
            p_d    = p_q + AW'(1);
            addr_d = p_q + AW'(1);
          end else begin
            c_d    = c_q + CW'(1);
            addr_d = addr_q + AW'(HW);
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          p_q <= '0;
          c_q <= '0;
        end else begin
          p_q <= p_d;
          c_q <= c_d;
        end
      end

      assign last_o = (p_q == P_LAST) && (c_q == C_LAST);
    end else begin : g_chw
      always_comb begin
        addr_d = addr_q;
        if (clear_i)     addr_d = '0;
        else if (step_i) addr_d = addr_q + AW'(1);
      end

      assign last_o = (addr_q == ADDR_LAST);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr_o = addr_q;
endmodule

// File: rtl/flatten_frame_sequencer.sv
// Streams one pooled feature map from the pool-output buffer into the Flatten
// layer with FC backpressure, and cross-checks Flatten's frame_done.
module flatten_frame_sequencer
  import flatten_frame_sequencer_pkg::*;
#(
  parameter int ORDER = ORDER_CHW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          buf_rd_en_o,
  output logic [AW-1:0] buf_addr_o,
  input  logic [DW-1:0] buf_dout_i,
  output logic          fl_en_o,
  output logic          fl_frame_start_o,
  output logic          fl_in_valid_o,
  output logic [DW-1:0] fl_din_o,
  input  logic          fl_frame_done_i,
  input  logic          ds_ready_i
);
  localparam logic [AW-1:0] EMIT_LAST = AW'(N - 1);

  state_e        state_q, state_d;
  logic          v1_q, v1_d;
  logic          rd_done_q, rd_done_d;
  logic          err_q, err_d;
  logic [AW-1:0] emit_q, emit_d;
  logic          adv, rd_en, beat, last_beat, rd_last;

  fm_addr_gen #(.ORDER(ORDER)) u_addr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (rd_en),
    .clear_i(state_q == S_PRIME),
    .addr_o (buf_addr_o),
    .last_o (rd_last)
  );

  always_comb begin
    state_d   = state_q;
    v1_d      = v1_q;
    rd_done_d = rd_done_q;
    emit_d    = emit_q;
    err_d     = err_q;
    adv       = !v1_q || ds_ready_i;
    rd_en     = (state_q == S_STREAM) && !rd_done_q && adv;
    beat      = (state_q == S_STREAM) && v1_q && ds_ready_i;
    last_beat = beat && (emit_q == EMIT_LAST);

    if (beat) begin
      emit_d = emit_q + AW'(1);
      if (fl_frame_done_i != (emit_q == EMIT_LAST)) err_d = 1'b1;
    end
    if (rd_en && rd_last)                rd_done_d = 1'b1;
    if ((state_q == S_STREAM) && adv)    v1_d      = rd_en;

    case (state_q)
      S_IDLE:   if (start_i && !abort_i) begin
                  state_d = S_PRIME;
                  err_d   = 1'b0;
                end
      S_PRIME:  begin
                  state_d   = S_STREAM;
                  emit_d    = '0;
                  rd_done_d = 1'b0;
                end
      S_STREAM: if (last_beat) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      v1_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      v1_q      <= 1'b0;
      rd_done_q <= 1'b0;
      err_q     <= 1'b0;
      emit_q    <= '0;
    end else begin
      state_q   <= state_d;
      v1_q      <= v1_d;
      rd_done_q <= rd_done_d;
      err_q     <= err_d;
      emit_q    <= emit_d;
    end
  end

  // The buffer holds its output while no read is issued, so its output
  // register doubles as the capture stage for the pending sample.
  assign fl_din_o         = v1_q ? buf_dout_i : '0;
  assign fl_in_valid_o    = beat;
  assign fl_en_o          = (state_q == S_PRIME) || (state_q == S_STREAM);
  assign fl_frame_start_o = (state_q == S_PRIME);
  assign buf_rd_en_o      = rd_en;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = err_q;
endmodule

// File: tb/tb_flatten_frame_sequencer.sv
// Runs a CHW and an HWC sequencer side by side on shared controls, each
// against a buffer model, a Flatten stub and a frame-level reference model.
module tb_flatten_frame_sequencer;
  import flatten_frame_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, abort = 1'b0, ds_ready = 1'b1;
  logic [1:0] busy, done, err, rd_en, fl_en, fl_fs, fl_iv, fl_fd;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] dout [2];
  logic [DW-1:0] din  [2];

  int checks = 0, failures = 0;
  int done_at = N - 1;
  bit rdy_rand = 1'b0;
  int sidx [2];

  flatten_frame_sequencer #(.ORDER(ORDER_CHW)) u_chw (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
    .buf_rd_en_o(rd_en[0]), .buf_addr_o(addr[0]), .buf_dout_i(dout[0]),
    .fl_en_o(fl_en[0]), .fl_frame_start_o(fl_fs[0]), .fl_in_valid_o(fl_iv[0]),
    .fl_din_o(din[0]), .fl_frame_done_i(fl_fd[0]), .ds_ready_i(ds_ready)
  );

  flatten_frame_sequencer #(.ORDER(ORDER_HWC)) u_hwc (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
    .buf_rd_en_o(rd_en[1]), .buf_addr_o(addr[1]), .buf_dout_i(dout[1]),
    .fl_en_o(fl_en[1]), .fl_frame_start_o(fl_fs[1]), .fl_in_valid_o(fl_iv[1]),
    .fl_din_o(din[1]), .fl_frame_done_i(fl_fd[1]), .ds_ready_i(ds_ready)
  );

  // Address of the k-th flattened sample for each ordering.
  function automatic int exp_addr(input int d, input int k);
    if (d == 0) return k;
    return (k % C) * HW + k / C;
  endfunction

  function automatic logic [DW-1:0] data_of(input int a);
    return DW'(a ^ (a >> 5));
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, d, $time, act, exp);
    end
  endtask

  // Buffer RAM (1-cycle read, holds output) and Flatten stub.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) dout[d] <= data_of(int'(addr[d]));
      if (fl_fs[d])      sidx[d] <= 0;
      else if (fl_iv[d]) sidx[d] <= sidx[d] + 1;
    end
  end

  always_comb begin
    fl_fd = '0;
    for (int d = 0; d < 2; d++) fl_fd[d] = fl_iv[d] && (sidx[d] == done_at);
  end

  // Frame-level reference: phase 0 idle, 1 prime, 2 stream, 3 done.
  int m_ph [2] = '{0, 0};
  int m_iss [2], m_bt [2], m_pc [2];
  bit m_err [2];
  int iv_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int first_cyc [2], done_cyc [2], a1 [2], a16 [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int outst;
      bit e_rd, e_iv;
      outst = m_iss[d] - m_bt[d];
      e_rd  = (m_ph[d] == 2) && (m_iss[d] < N) && (outst == 0 || ds_ready);
      e_iv  = (m_ph[d] == 2) && (outst > 0) && ds_ready;

      chk("busy",           d, int'(busy[d]),  int'(m_ph[d] != 0));
      chk("fl_en",          d, int'(fl_en[d]), int'(m_ph[d] == 1 || m_ph[d] == 2));
      chk("fl_frame_start", d, int'(fl_fs[d]), int'(m_ph[d] == 1));
      chk("done",           d, int'(done[d]),  int'(m_ph[d] == 3));
      chk("buf_rd_en",      d, int'(rd_en[d]), int'(e_rd));
      chk("fl_in_valid",    d, int'(fl_iv[d]), int'(e_iv));
      chk("err",            d, int'(err[d]),   int'(m_err[d]));
      if (rd_en[d] && e_rd) begin
        chk("buf_addr", d, int'(addr[d]), exp_addr(d, m_iss[d]));
        if (m_iss[d] == 1)  a1[d]  = int'(addr[d]);
        if (m_iss[d] == 16) a16[d] = int'(addr[d]);
      end
      if (fl_iv[d] && e_iv)
        chk("fl_din", d, int'(din[d]), int'(data_of(exp_addr(d, m_bt[d]))));

      if (fl_fs[d]) iv_cnt[d] = 0;
      if (fl_iv[d]) iv_cnt[d]++;
      if (done[d])  done_cnt[d]++;

      if (rst) begin
        m_ph[d]  = 0;
        m_err[d] = 1'b0;
      end else begin
        if (m_ph[d] == 2) begin
          if (e_rd) m_iss[d]++;
          if (e_iv) begin
            if (fl_fd[d] != (m_bt[d] == N - 1)) m_err[d] = 1'b1;
            if (m_bt[d] == 0) first_cyc[d] = m_pc[d];
            m_bt[d]++;
          end
        end
        if (m_ph[d] == 3) done_cyc[d] = m_pc[d];
        m_pc[d]++;
        if (abort && m_ph[d] != 0) m_ph[d] = 0;
        else case (m_ph[d])
          0: if (start && !abort) begin m_ph[d] = 1; m_err[d] = 1'b0; m_pc[d] = 0; end
          1: begin m_ph[d] = 2; m_iss[d] = 0; m_bt[d] = 0; end
          2: if (m_bt[d] == N) m_ph[d] = 3;
          default: m_ph[d] = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
    ds_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int n0, n1;
    n0 = done_cnt[0];
    n1 = done_cnt[1];
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt[0] > n0 && done_cnt[1] > n1) return;
      step();
    end
    checks++;
    failures++;
    $display("FAIL %s timeout got=no_done want=done", nm);
  endtask

  task automatic wait_beats(input string nm, input int tgt);
    for (int i = 0; i < 20000; i++) begin
      if (iv_cnt[0] >= tgt) return;
      step();
    end
    checks++;
    failures++;
    $display("FAIL %s timeout got=%0d want=%0d beats", nm, iv_cnt[0], tgt);
  endtask

  initial begin
    int dc0;
    repeat (3) step();
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",  d, int'(busy[d]),  0);
      chk("rst_err",   d, int'(err[d]),   0);
      chk("rst_rd_en", d, int'(rd_en[d]), 0);
      chk("rst_fl_en", d, int'(fl_en[d]), 0);
    end

    // Full-rate frame: latency and HWC address pins.
    start = 1'b1;
    step();
    wait_done("frameA");
    for (int d = 0; d < 2; d++) begin
      chk("A_first_beat_cyc", d, first_cyc[d], 2);
      chk("A_done_cyc",       d, done_cyc[d],  N + 2);
      chk("A_beats",          d, iv_cnt[d],    N);
      chk("A_addr1",          d, a1[d],        (d == 0) ? 1 : 196);
      chk("A_addr16",         d, a16[d],       (d == 0) ? 16 : 1);
      chk("A_done_cnt",       d, done_cnt[d],  1);
      chk("A_err",            d, int'(err[d]), 0);
    end

    // Random backpressure.
    rdy_rand = 1'b1;
    start = 1'b1;
    step();
    wait_done("frameB");
    for (int d = 0; d < 2; d++) chk("B_beats", d, iv_cnt[d], N);

    // Abort at beat 1000.
    rdy_rand = 1'b0;
    start = 1'b1;
    step();
    wait_beats("frameC", 1000);
    dc0 = done_cnt[0];
    abort = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("C_fl_en_after_abort", d, int'(fl_en[d]), 0);
      chk("C_busy_after_abort",  d, int'(busy[d]),  0);
    end
    repeat (5) step();
    chk("C_no_done", 0, done_cnt[0], dc0);

    rdy_rand = 1'b1;
    start = 1'b1;
    step();
    wait_done("frameD");
    for (int d = 0; d < 2; d++) chk("D_beats", d, iv_cnt[d], N);

    // Early frame_done from Flatten.
    done_at = 3134;
    start = 1'b1;
    step();
    wait_done("frameE");
    for (int d = 0; d < 2; d++) chk("E_err_sticky", d, int'(err[d]), 1);
    done_at = N - 1;
    start = 1'b1;
    step();
    for (int d = 0; d < 2; d++) chk("E_err_cleared", d, int'(err[d]), 0);
    wait_done("frameE2");

    // Stray starts mid-stream, then reset mid-frame.
    start = 1'b1;
    step();
    wait_beats("frameF", 100);
    start = 1'b1;
    step();
    wait_beats("frameF", 500);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) chk("F_busy_after_rst", d, int'(busy[d]), 0);
    start = 1'b1;
    step();
    wait_beats("frameG", 1500);
    start = 1'b1;
    step();
    wait_done("frameG");
    for (int d = 0; d < 2; d++) begin
      chk("G_beats", d, iv_cnt[d],    N);
      chk("G_err",   d, int'(err[d]), 0);
    end
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
